// File: rtl/sysu_pkg.sv
// Constants and types shared by the systolic-unit result drain logic.
package sysu_pkg;
  localparam int WL = 32;

  localparam logic [31:0] FP_ONE   = 32'h3F800000;
  localparam logic [31:0] FP_THREE = 32'h40400000;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } collect_state_t;
endpackage

// File: rtl/sysu_result_slot.sv
// One PE result slot: a holding register and its pending bit. It pulses
// overflow_o when a result arrives for a slot that is still occupied.
module sysu_result_slot #(
  parameter int WL = sysu_pkg::WL
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          capture_i,
  input  logic [WL-1:0] value_i,
  input  logic          unload_i,
  output logic [WL-1:0] slot_val_o,
  output logic          pend_o,
  output logic          overflow_o
);
  logic [WL-1:0] val_q;
  logic          pend_q;
  logic          capture;

  assign capture    = ena && capture_i;
  // A slot being unloaded on this edge is free again, so the capture is not a drop.
  assign overflow_o = capture && pend_q && !unload_i;
  assign slot_val_o = val_q;
  assign pend_o     = pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      pend_q <= 1'b0;
    end else if (capture && (!pend_q || unload_i)) begin
      val_q  <= value_i;
      pend_q <= 1'b1;
    end else if (unload_i) begin
      pend_q <= 1'b0;
    end
  end
endmodule

// File: rtl/sysu_result_collector.sv
// Collects one result per PE, then streams the row out in ascending PE order
// over a valid/ready interface.
module sysu_result_collector #(
  parameter int WL  = sysu_pkg::WL,
  parameter int NPE = 4,
  parameter int IW  = $clog2(NPE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [NPE-1:0]    resultvalid,
  input  logic [NPE*WL-1:0] resultvalue,
  output logic [WL-1:0]     outvalue,
  output logic              outvalid,
  input  logic              outready,
  output logic [IW-1:0]     outindex,
  output logic              outlast,
  output logic              busy,
  output logic              overflow
);
  import sysu_pkg::*;

  localparam logic [IW-1:0] LAST_IDX = IW'(NPE - 1);

  collect_state_t state_q, state_d;
  logic [WL-1:0]  out_value_q, out_value_d;
  logic           out_valid_q, out_valid_d;
  logic [IW-1:0]  out_index_q, out_index_d;
  logic           overflow_q;

  logic [NPE-1:0] unload;
  logic [NPE-1:0] pend;
  logic [NPE-1:0] ovf_pulse;
  logic [WL-1:0]  slot_val [NPE];
  logic [IW-1:0]  next_index;
  logic           handshake;

  genvar gi;
  generate
    for (gi = 0; gi < NPE; gi++) begin : g_slot
      sysu_result_slot #(.WL(WL)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .capture_i  (resultvalid[gi]),
        .value_i    (resultvalue[gi*WL +: WL]),
        .unload_i   (unload[gi]),
        .slot_val_o (slot_val[gi]),
        .pend_o     (pend[gi]),
        .overflow_o (ovf_pulse[gi])
      );
    end
  endgenerate

  assign handshake  = ena && out_valid_q && outready;
  assign next_index = out_index_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    out_value_d = out_value_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    unload      = '0;
    if (ena) begin
      case (state_q)
        COLLECT: begin
          if (&pend) begin
            state_d     = DRAIN;
            out_value_d = slot_val[0];
            out_valid_d = 1'b1;
            out_index_d = '0;
            unload[0]   = 1'b1;
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (out_index_q == LAST_IDX) begin
              out_valid_d = 1'b0;
              state_d     = COLLECT;
            end else begin
              out_value_d        = slot_val[next_index];
              out_index_d        = next_index;
              unload[next_index] = 1'b1;
            end
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      out_value_q <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_value_q <= out_value_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      overflow_q  <= overflow_q | (|ovf_pulse);
    end
  end

  assign outvalue = out_value_q;
  assign outvalid = out_valid_q;
  assign outindex = out_index_q;
  assign outlast  = out_valid_q && (out_index_q == LAST_IDX);
  assign busy     = (state_q == DRAIN);
  assign overflow = overflow_q;
endmodule

// File: tb/tb_sysu_result_collector.sv
// Directed bench for sysu_result_collector with NPE=4.
module tb_sysu_result_collector;
  localparam int NPE = 4;
  localparam int WL  = 32;
  localparam int IW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              ena;
  logic [NPE-1:0]    resultvalid;
  logic [NPE*WL-1:0] resultvalue;
  logic [WL-1:0]     outvalue;
  logic              outvalid;
  logic              outready;
  logic [IW-1:0]     outindex;
  logic              outlast;
  logic              busy;
  logic              overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sysu_result_collector #(.WL(WL), .NPE(NPE)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .resultvalid (resultvalid),
    .resultvalue (resultvalue),
    .outvalue    (outvalue),
    .outvalid    (outvalid),
    .outready    (outready),
    .outindex    (outindex),
    .outlast     (outlast),
    .busy        (busy),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input int idx, input logic [31:0] val);
    check({tag, ".valid"}, 32'(outvalid), 32'd1);
    check({tag, ".index"}, 32'(outindex), 32'(idx));
    check({tag, ".value"}, outvalue, val);
    check({tag, ".last"},  32'(outlast), (idx == NPE - 1) ? 32'd1 : 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd1);
    $display("[TB] %s word idx=%0d value=%h", tag, outindex, outvalue);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"}, 32'(outvalid), 32'd0);
    check({tag, ".last"},  32'(outlast), 32'd0);
    check({tag, ".busy"},  32'(busy), 32'd0);
    $display("[TB] %s idle", tag);
  endtask

  task automatic set_val(input int pe, input logic [31:0] v);
    resultvalue[pe*WL +: WL] = v;
  endtask

  task automatic pulse(input int pe, input logic [31:0] v);
    set_val(pe, v);
    resultvalid[pe] = 1'b1;
    tick();
    resultvalid = '0;
  endtask

  task automatic load_row(input logic [31:0] v0, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [31:0] v3);
    set_val(0, v0); set_val(1, v1); set_val(2, v2); set_val(3, v3);
    resultvalid = 4'hF;
    tick();
    resultvalid = '0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; outready = 1'b1;
    resultvalid = '0; resultvalue = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset.outvalue", outvalue, 32'h0);
    check("reset.outindex", 32'(outindex), 32'd0);
    check("reset.overflow", 32'(overflow), 32'd0);
    expect_idle("reset");

    // Single row: all PEs in one cycle, words from two cycles later.
    load_row(sysu_pkg::FP_ONE, sysu_pkg::FP_THREE, 32'h40800000, 32'h40A00000);
    expect_idle("row1.lat");
    tick(); expect_word("row1.w0", 0, 32'h3F800000);
    tick(); expect_word("row1.w1", 1, 32'h40400000);
    tick(); expect_word("row1.w2", 2, 32'h40800000);
    tick(); expect_word("row1.w3", 3, 32'h40A00000);
    tick(); expect_idle("row1.end");
    check("row1.overflow", 32'(overflow), 32'd0);

    // Staggered arrival in cycles 0, 3, 5, 9; first word in cycle 11.
    pulse(0, 32'h41000000);
    tick(); tick();
    pulse(1, 32'h41100000);
    tick();
    pulse(2, 32'h41200000);
    tick(); tick(); tick();
    pulse(3, 32'h41300000);
    expect_idle("stag.c10");
    tick(); expect_word("stag.w0", 0, 32'h41000000);
    tick(); expect_word("stag.w1", 1, 32'h41100000);
    tick(); expect_word("stag.w2", 2, 32'h41200000);
    tick(); expect_word("stag.w3", 3, 32'h41300000);
    tick(); expect_idle("stag.end");

    // Backpressure: hold index 1 for five cycles.
    load_row(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    tick(); expect_word("bp.w0", 0, 32'h11111111);
    tick(); expect_word("bp.w1", 1, 32'h22222222);
    outready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); expect_word("bp.hold", 1, 32'h22222222);
    end
    outready = 1'b1;
    tick(); expect_word("bp.w2", 2, 32'h33333333);
    tick(); expect_word("bp.w3", 3, 32'h44444444);
    tick(); expect_idle("bp.end");

    // Overflow: PE 2 strobes twice; the second value is dropped.
    pulse(2, sysu_pkg::FP_ONE);
    check("ovf.first", 32'(overflow), 32'd0);
    pulse(2, sysu_pkg::FP_THREE);
    check("ovf.second", 32'(overflow), 32'd1);
    set_val(0, 32'hA0000000); set_val(1, 32'hA1000000); set_val(3, 32'hA3000000);
    resultvalid = 4'b1011;
    tick();
    resultvalid = '0;
    tick(); expect_word("ovf.w0", 0, 32'hA0000000);
    tick(); expect_word("ovf.w1", 1, 32'hA1000000);
    tick(); expect_word("ovf.w2", 2, sysu_pkg::FP_ONE);
    tick(); expect_word("ovf.w3", 3, 32'hA3000000);
    tick(); expect_idle("ovf.end");
    check("ovf.sticky", 32'(overflow), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("ovf.cleared", 32'(overflow), 32'd0);

    // Capture into an already-unloaded slot during drain.
    load_row(32'hB0000000, 32'hB1000000, 32'hB2000000, 32'hB3000000);
    tick(); expect_word("cdr.w0", 0, 32'hB0000000);
    tick(); expect_word("cdr.w1", 1, 32'hB1000000);
    tick(); expect_word("cdr.w2", 2, 32'hB2000000);
    set_val(0, sysu_pkg::FP_THREE);
    resultvalid = 4'b0001;
    tick();
    resultvalid = '0;
    expect_word("cdr.w3", 3, 32'hB3000000);
    check("cdr.noovf", 32'(overflow), 32'd0);
    tick(); expect_idle("cdr.end");
    set_val(1, 32'hC1000000); set_val(2, 32'hC2000000); set_val(3, 32'hC3000000);
    resultvalid = 4'b1110;
    tick();
    resultvalid = '0;
    tick(); expect_word("cdr2.w0", 0, sysu_pkg::FP_THREE);
    tick(); expect_word("cdr2.w1", 1, 32'hC1000000);
    tick(); expect_word("cdr2.w2", 2, 32'hC2000000);
    tick(); expect_word("cdr2.w3", 3, 32'hC3000000);
    tick(); expect_idle("cdr2.end");
    check("cdr2.noovf", 32'(overflow), 32'd0);

    // Enable freeze mid-drain, then a reset mid-drain.
    load_row(32'hD0000000, 32'hD1000000, 32'hD2000000, 32'hD3000000);
    tick(); expect_word("ena.w0", 0, 32'hD0000000);
    tick(); expect_word("ena.w1", 1, 32'hD1000000);
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_word("ena.frozen", 1, 32'hD1000000);
    end
    ena = 1'b1;
    tick(); expect_word("ena.w2", 2, 32'hD2000000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.outvalue", outvalue, 32'h0);
    check("rst.outindex", 32'(outindex), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    expect_idle("rst");
    load_row(32'hE0000000, 32'hE1000000, 32'hE2000000, 32'hE3000000);
    expect_idle("rst.lat");
    tick(); expect_word("rst.w0", 0, 32'hE0000000);
    tick(); expect_word("rst.w1", 1, 32'hE1000000);
    tick(); expect_word("rst.w2", 2, 32'hE2000000);
    tick(); expect_word("rst.w3", 3, 32'hE3000000);
    tick(); expect_idle("rst.end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
